// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pc_ctrl_pkg: shared fetch types and constants for the instruction-fetch PC controller.
package fetch_pc_ctrl_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;
    typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_pc_ctrl_pc_adder.sv
// pc_adder: PC plus immediate, wrapping modulo 2^XLEN.
module pc_adder import fetch_pc_ctrl_pkg::*; (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] result
);
    assign result = pc + imm;
endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch PC, one-outstanding imem requests and a one-entry decode buffer.
// Optional PC_MISALIGN_TRAP_EN: misaligned redirect targets trap to TRAP_VECTOR.
module fetch_pc_ctrl import fetch_pc_ctrl_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o,
    input  logic            if_ready_i,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
);
    fetch_state_t    state;
    logic [XLEN-1:0] pc_q, pc_inc, load_pc;
    logic            drop_q, req_hs, bad_target, redirect_drop;

    pc_adder u_pc_adder (.pc(pc_q), .imm(INSTR_BYTES), .result(pc_inc));

    assign imem_req_valid_o = state == REQ;
    assign imem_req_addr_o  = pc_q;
    assign req_hs           = imem_req_valid_o && imem_req_ready_i;
    // A redirect leaves a request in flight exactly when its response is still to come
    assign redirect_drop    = state == WAIT ? !imem_rsp_valid_i : req_hs;

`ifdef PC_MISALIGN_TRAP_EN
    assign bad_target = |redirect_target_i[1:0];
    assign load_pc    = bad_target ? TRAP_VECTOR : redirect_target_i;
`else
    logic unused_bits;
    assign bad_target  = 1'b0;
    assign load_pc     = {redirect_target_i[XLEN-1:2], 2'b00};
    assign unused_bits = ^{redirect_target_i[1:0], TRAP_VECTOR};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= REQ;
            pc_q            <= RESET_VECTOR;
            drop_q          <= 1'b0;
            if_valid_o      <= 1'b0;
            if_pc_o         <= '0;
            if_instr_o      <= '0;
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            misalign_o <= redirect_valid_i && bad_target;
            if (redirect_valid_i && bad_target)
                misalign_addr_o <= redirect_target_i;
            if (redirect_valid_i) begin
                pc_q       <= load_pc;
                if_valid_o <= 1'b0;
                drop_q     <= redirect_drop;
                state      <= redirect_drop ? WAIT : REQ;
            end else begin
                case (state)
                    REQ: if (req_hs) state <= WAIT;
                    WAIT: if (imem_rsp_valid_i) begin
                        if (!drop_q) begin
                            if_valid_o <= 1'b1;
                            if_pc_o    <= pc_q;
                            if_instr_o <= imem_rsp_data_i;
                        end
                        drop_q <= 1'b0;
                        state  <= drop_q ? REQ : HOLD;
                    end
                    HOLD: if (if_ready_i) begin
                        if_valid_o <= 1'b0;
                        pc_q       <= pc_inc;
                        state      <= REQ;
                    end
                    default: state <= REQ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: random redirects/handshakes against an architectural-PC scoreboard.
module tb_fetch_pc_ctrl;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;
    localparam int CYCLES = 3000;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        redirect_valid_i = 1'b0, imem_req_ready_i = 1'b0, imem_rsp_valid_i = 1'b0, if_ready_i = 1'b0;
    logic [31:0] redirect_target_i = '0, imem_rsp_data_i = '0;
    logic        imem_req_valid_o, if_valid_o, misalign_o;
    logic [31:0] imem_req_addr_o, if_pc_o, if_instr_o, misalign_addr_o;

    always #5 clk = ~clk;

    fetch_pc_ctrl #(.RESET_VECTOR(RESET_VECTOR), .TRAP_VECTOR(TRAP_VECTOR)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
        .imem_req_ready_i(imem_req_ready_i), .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i(imem_rsp_data_i), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o),
        .if_instr_o(if_instr_o), .if_ready_i(if_ready_i),
        .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o)
    );

    int          n_checks = 0, n_fail = 0, delivered = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_pc, nxt_pc = RESET_VECTOR, cur_maddr, nxt_maddr = '0;
    logic        cur_mis, nxt_mis = 1'b0, cur_flush, nxt_flush = 1'b0, pend = 1'b0;
    logic [31:0] targets[6] = '{32'h0000_0200, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0000_0102, 32'h0000_0FF1, 32'h0000_0000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Environment (memory + decode + redirects) and the architectural-PC model
    task automatic drive();
        logic        hs_prev = 1'b0, mis;
        logic [31:0] addr_prev = '0, pend_addr = '0, t;
        int          delay = 0, k;
        for (int c = 0; c < CYCLES; c++) begin
            @(posedge clk); #1;
            cur_pc = nxt_pc; cur_mis = nxt_mis; cur_maddr = nxt_maddr; cur_flush = nxt_flush;
            if (hs_prev) begin
                pend = 1'b1; pend_addr = addr_prev; delay = $urandom_range(0, 3);
            end
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
            if (pend) begin
                if (delay == 0) begin
                    imem_rsp_valid_i = 1'b1;
                    imem_rsp_data_i  = mem_word(pend_addr);
                    pend = 1'b0;
                end else delay--;
            end
            imem_req_ready_i = $urandom_range(0, 3) != 0;
            hs_prev   = imem_req_valid_o && imem_req_ready_i;
            addr_prev = imem_req_addr_o;
            if_ready_i       = $urandom_range(0, 3) != 0;
            redirect_valid_i = $urandom_range(0, 7) == 0;
            k = $urandom_range(0, 6);
            t = k == 6 ? $urandom : targets[k];
            redirect_target_i = t;
            nxt_mis   = 1'b0;
            nxt_flush = redirect_valid_i;
            if (redirect_valid_i) begin
                mis     = TRAP_EN && t[1:0] != 2'b00;
                nxt_pc  = mis ? TRAP_VECTOR : {t[31:2], 2'b00};
                nxt_mis = mis;
                if (mis) nxt_maddr = t;
                exp_q.delete();
                exp_q.push_back(nxt_pc);
            end else if (if_valid_o && if_ready_i) begin
                nxt_pc = cur_pc + 32'd4;
                exp_q.push_back(nxt_pc);
            end
        end
    endtask

    task automatic monitor();
        for (int c = 0; c < CYCLES; c++) begin
            @(negedge clk);
            if (imem_req_valid_o) begin
                check("req_addr", imem_req_addr_o, cur_pc);
                check("one_outstanding", {31'b0, pend}, 32'd0);
            end
            if (cur_flush) check("flush", {31'b0, if_valid_o}, 32'd0);
            if (if_valid_o && !redirect_valid_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_instr: got pc %h expected none", if_pc_o);
                end else begin
                    check("if_pc", if_pc_o, exp_q[0]);
                    check("if_instr", if_instr_o, mem_word(exp_q[0]));
                    check("no_prefetch", {31'b0, imem_req_valid_o}, 32'd0);
                    if (if_ready_i) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
            check("misalign", {31'b0, misalign_o}, {31'b0, cur_mis});
            check("misalign_addr", misalign_addr_o, cur_maddr);
        end
    endtask

    initial begin
        exp_q.push_back(RESET_VECTOR);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid_o}, 32'd1);
        check("rst_addr", imem_req_addr_o, RESET_VECTOR);
        check("rst_if_valid", {31'b0, if_valid_o}, 32'd0);
        check("rst_if_pc", if_pc_o, 32'd0);
        check("rst_if_instr", if_instr_o, 32'd0);
        check("rst_misalign", {31'b0, misalign_o}, 32'd0);
        check("rst_misalign_addr", misalign_addr_o, 32'd0);
        rst_n = 1'b1;
        fork
            drive();
            monitor();
        join
        check("progress", {31'b0, delivered >= 50}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
